// File: rtl/tx_link_pkg.sv
// Shared definitions for the 4-lane link: symbols, lane geometry and the
// Tx scheduler state encoding.
package tx_link_pkg;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned BYTE_BITS = 8;

  localparam logic [BYTE_BITS-1:0] COM_SYMBOL  = 8'hBC;
  localparam logic [BYTE_BITS-1:0] IDLE_SYMBOL = 8'hBC;

  typedef logic [BYTE_BITS-1:0] link_byte_t;

  typedef enum logic {
    ALIGN  = 1'b0,
    ACTIVE = 1'b1
  } link_state_e;

endpackage

// File: rtl/tx_lane_scheduler_if.sv
// Lane sources and serializer handoff of the Tx scheduler; master is the
// scheduler side, slave is the environment (lane sources + serializer).
interface tx_lane_scheduler_if;
  import tx_link_pkg::*;

  link_byte_t in0, in1, in2, in3;
  logic       valid_in0, valid_in1, valid_in2, valid_in3;
  logic       ack_out0, ack_out1, ack_out2, ack_out3;
  link_byte_t byte_out;
  logic       byte_load;
  logic [1:0] lane_sel;
  logic       aligned;
  logic       idle_ins;

  modport master (
    input  in0, in1, in2, in3,
    input  valid_in0, valid_in1, valid_in2, valid_in3,
    output ack_out0, ack_out1, ack_out2, ack_out3,
    output byte_out, byte_load, lane_sel, aligned, idle_ins
  );

  modport slave (
    output in0, in1, in2, in3,
    output valid_in0, valid_in1, valid_in2, valid_in3,
    input  ack_out0, ack_out1, ack_out2, ack_out3,
    input  byte_out, byte_load, lane_sel, aligned, idle_ins
  );

endinterface

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin arbiter: first valid lane at or after
// rr_ptr, wrapping modulo 4. Shared by the Tx and Rx sides.
module rr_arbiter4 (
  input  logic [3:0] valid,
  input  logic [1:0] rr_ptr,
  output logic       grant_valid,
  output logic [1:0] grant_idx
);

  logic [7:0] doubled;
  logic [3:0] rotated;
  logic [1:0] offset;

  // Rotating by rr_ptr turns the search into a fixed-priority pick from bit 0.
  assign doubled = {valid, valid};
  assign rotated = doubled[rr_ptr +: 4];

  always_comb begin
    offset = 2'd0;
    if (rotated[0])      offset = 2'd0;
    else if (rotated[1]) offset = 2'd1;
    else if (rotated[2]) offset = 2'd2;
    else if (rotated[3]) offset = 2'd3;
  end

  assign grant_valid = |rotated;
  assign grant_idx   = rr_ptr + offset;

endmodule

// File: rtl/tx_lane_scheduler.sv
// Tx byte scheduler: 8-cycle slot timing, COM preamble until aligned, then
// round-robin sharing of the serializer slot among four lanes with IDLE fill.
module tx_lane_scheduler
  import tx_link_pkg::*;
#(
  parameter int unsigned SYNC_COUNT = 4,
  parameter link_byte_t  COM_SYM    = COM_SYMBOL,
  parameter link_byte_t  IDLE_SYM   = IDLE_SYMBOL
) (
  input  logic                 clk_32f,
  input  logic                 reset_L,
  input  logic                 link_en,
  tx_lane_scheduler_if.master  lane_if
);

  link_state_e    state_q, state_d;
  logic [2:0]     bit_cnt_q;
  logic [3:0]     sync_cnt_q, sync_cnt_d;
  logic [1:0]     rr_ptr_q, rr_ptr_d;
  link_byte_t     byte_out_q, byte_out_d;
  logic [1:0]     lane_sel_q, lane_sel_d;
  logic           byte_load_q, byte_load_d;
  logic [NUM_LANES-1:0] ack_q, ack_d;
  logic           idle_q, idle_d;

  logic           decision;
  logic [4:0]     sync_next;
  logic [NUM_LANES-1:0] valid_vec;
  link_byte_t     lane_data [NUM_LANES];
  logic           grant_valid;
  logic [1:0]     grant_idx;

  assign valid_vec    = {lane_if.valid_in3, lane_if.valid_in2, lane_if.valid_in1, lane_if.valid_in0};
  assign lane_data[0] = lane_if.in0;
  assign lane_data[1] = lane_if.in1;
  assign lane_data[2] = lane_if.in2;
  assign lane_data[3] = lane_if.in3;

  assign decision  = (bit_cnt_q == 3'd7);
  assign sync_next = {1'b0, sync_cnt_q} + 5'd1;

  rr_arbiter4 u_arb (
    .valid       (valid_vec),
    .rr_ptr      (rr_ptr_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_ff @(posedge clk_32f) begin
    if (!reset_L) begin
      state_q     <= ALIGN;
      bit_cnt_q   <= 3'd0;
      sync_cnt_q  <= 4'd0;
      rr_ptr_q    <= 2'd0;
      byte_out_q  <= '0;
      lane_sel_q  <= 2'd0;
      byte_load_q <= 1'b0;
      ack_q       <= '0;
      idle_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_q + 3'd1;
      sync_cnt_q  <= sync_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      byte_out_q  <= byte_out_d;
      lane_sel_q  <= lane_sel_d;
      byte_load_q <= byte_load_d;
      ack_q       <= ack_d;
      idle_q      <= idle_d;
    end
  end

  // Everything holds between decision edges; pulses fall back to 0 one cycle later.
  always_comb begin
    state_d     = state_q;
    sync_cnt_d  = sync_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    byte_out_d  = byte_out_q;
    lane_sel_d  = lane_sel_q;
    byte_load_d = 1'b0;
    ack_d       = '0;
    idle_d      = 1'b0;

    if (decision) begin
      byte_load_d = 1'b1;
      case (state_q)
        ALIGN: begin
          byte_out_d = COM_SYM;
          lane_sel_d = 2'd0;
          if (sync_next >= 5'(SYNC_COUNT)) begin
            state_d    = ACTIVE;
            sync_cnt_d = 4'd0;
          end else begin
            sync_cnt_d = sync_next[3:0];
          end
        end
        ACTIVE: begin
          // The COM sent on a link drop is the first symbol of the new preamble.
          if (!link_en) begin
            byte_out_d = COM_SYM;
            lane_sel_d = 2'd0;
            state_d    = ALIGN;
            sync_cnt_d = 4'd1;
          end else if (grant_valid) begin
            byte_out_d       = lane_data[grant_idx];
            lane_sel_d       = grant_idx;
            ack_d[grant_idx] = 1'b1;
            rr_ptr_d         = grant_idx + 2'd1;
          end else begin
            byte_out_d = IDLE_SYM;
            lane_sel_d = 2'd0;
            idle_d     = 1'b1;
          end
        end
        default: state_d = ALIGN;
      endcase
    end
  end

  assign lane_if.byte_out  = byte_out_q;
  assign lane_if.byte_load = byte_load_q;
  assign lane_if.lane_sel  = lane_sel_q;
  assign lane_if.aligned   = (state_q == ACTIVE);
  assign lane_if.idle_ins  = idle_q;
  assign lane_if.ack_out0  = ack_q[0];
  assign lane_if.ack_out1  = ack_q[1];
  assign lane_if.ack_out2  = ack_q[2];
  assign lane_if.ack_out3  = ack_q[3];

endmodule

// File: tb/tb_tx_lane_scheduler.sv
// Randomized bench for tx_lane_scheduler: a default instance and one with
// SYNC_COUNT=1 / IDLE_SYM=7C, both compared each cycle against a slot-level model.
module tb_tx_lane_scheduler;

  logic clk = 1'b0;
  logic resetL = 1'b0;
  logic linkEn = 1'b1;

  tx_lane_scheduler_if ifA ();
  tx_lane_scheduler_if ifB ();

  tx_lane_scheduler dutA (
    .clk_32f (clk),
    .reset_L (resetL),
    .link_en (linkEn),
    .lane_if (ifA.master)
  );

  tx_lane_scheduler #(
    .SYNC_COUNT (1),
    .IDLE_SYM   (8'h7C)
  ) dutB (
    .clk_32f (clk),
    .reset_L (resetL),
    .link_en (linkEn),
    .lane_if (ifB.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int         syncCfg [2] = '{4, 1};
  logic [7:0] idleCfg [2] = '{8'hBC, 8'h7C};
  logic [7:0] fixedByte [4] = '{8'hBD, 8'hBA, 8'hAB, 8'h11};

  // Slot-level reference: alignment flag, preamble count and next lane to favour.
  bit         mAligned [2];
  int         mPre [2];
  int         mPtr [2];
  logic [7:0] eByte [2];
  logic [1:0] eLane [2];
  logic [5:0] ePulse [2];

  bit         srcPend [2][4];
  logic [7:0] srcByte [2][4];
  logic [3:0] drvValid [2];
  logic [7:0] drvData [2][4];

  int mode = 0;
  bit linkTarget = 1'b1;
  int cnt = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic driveIf(input int d);
    if (d == 0) begin
      ifA.in0 = drvData[0][0]; ifA.in1 = drvData[0][1];
      ifA.in2 = drvData[0][2]; ifA.in3 = drvData[0][3];
      {ifA.valid_in3, ifA.valid_in2, ifA.valid_in1, ifA.valid_in0} = drvValid[0];
    end else begin
      ifB.in0 = drvData[1][0]; ifB.in1 = drvData[1][1];
      ifB.in2 = drvData[1][2]; ifB.in3 = drvData[1][3];
      {ifB.valid_in3, ifB.valid_in2, ifB.valid_in1, ifB.valid_in0} = drvValid[1];
    end
  endtask

  // Sources hold their byte until acked; pins are scrambled only between decision edges.
  task automatic applyStimulus(input bit nextDecision);
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 4; k++) begin
        case (mode)
          0: srcPend[d][k] = 1'b0;
          1: begin
            srcPend[d][k] = 1'b1;
            srcByte[d][k] = fixedByte[k];
          end
          2: begin
            if (k == 1 || k == 2) srcPend[d][k] = 1'b0;
            else if (!srcPend[d][k]) begin
              srcPend[d][k] = 1'b1;
              srcByte[d][k] = 8'($urandom);
            end
          end
          default: begin
            if (!srcPend[d][k]) begin
              srcPend[d][k] = 1'($urandom_range(0, 1));
              srcByte[d][k] = 8'($urandom);
            end
          end
        endcase
        drvValid[d][k] = srcPend[d][k];
        drvData[d][k]  = srcPend[d][k] ? srcByte[d][k] : 8'($urandom);
        if (!nextDecision && $urandom_range(0, 3) == 0)
          drvValid[d][k] = ~drvValid[d][k];
      end
      driveIf(d);
    end
    linkEn = nextDecision ? linkTarget : 1'($urandom_range(0, 1));
  endtask

  task automatic modelStep(input int d, input bit decision);
    int found;
    int k;
    if (!resetL) begin
      mAligned[d] = 1'b0;
      mPre[d]     = 0;
      mPtr[d]     = 0;
      eByte[d]    = 8'h00;
      eLane[d]    = 2'd0;
      ePulse[d]   = 6'd0;
      return;
    end
    ePulse[d] = 6'd0;
    if (!decision) return;
    ePulse[d][5] = 1'b1;
    if (!mAligned[d]) begin
      eByte[d] = 8'hBC;
      eLane[d] = 2'd0;
      mPre[d]++;
      if (mPre[d] >= syncCfg[d]) begin
        mAligned[d] = 1'b1;
        mPre[d]     = 0;
      end
    end else if (!linkEn) begin
      eByte[d]    = 8'hBC;
      eLane[d]    = 2'd0;
      mAligned[d] = 1'b0;
      mPre[d]     = 1;
    end else begin
      found = -1;
      for (int i = 0; i < 4; i++) begin
        k = (mPtr[d] + i) % 4;
        if (found < 0 && drvValid[d][k]) found = k;
      end
      if (found >= 0) begin
        eByte[d]         = drvData[d][found];
        eLane[d]         = 2'(found);
        ePulse[d][found] = 1'b1;
        mPtr[d]          = (found + 1) % 4;
        if (mode != 1) srcPend[d][found] = 1'b0;
      end else begin
        eByte[d]     = idleCfg[d];
        eLane[d]     = 2'd0;
        ePulse[d][4] = 1'b1;
      end
    end
  endtask

  task automatic runCycle(input logic rstNext);
    bit nextDecision;
    bit decision;
    logic [7:0] oByte;
    logic [1:0] oLane;
    logic       oAligned;
    logic [5:0] oPulse;
    nextDecision = rstNext && ((cnt + 1) % 8 == 0);
    resetL = rstNext;
    applyStimulus(nextDecision);
    @(posedge clk);
    #1;
    if (!resetL) cnt = 0;
    else cnt++;
    decision = resetL && (cnt % 8 == 0);
    for (int d = 0; d < 2; d++) begin
      modelStep(d, decision);
      if (d == 0) begin
        oByte = ifA.byte_out; oLane = ifA.lane_sel; oAligned = ifA.aligned;
        oPulse = {ifA.byte_load, ifA.idle_ins, ifA.ack_out3, ifA.ack_out2, ifA.ack_out1, ifA.ack_out0};
      end else begin
        oByte = ifB.byte_out; oLane = ifB.lane_sel; oAligned = ifB.aligned;
        oPulse = {ifB.byte_load, ifB.idle_ins, ifB.ack_out3, ifB.ack_out2, ifB.ack_out1, ifB.ack_out0};
      end
      checkOutput($sformatf("byte_out[%0d]", d), 32'(oByte), 32'(eByte[d]));
      checkOutput($sformatf("lane_sel[%0d]", d), 32'(oLane), 32'(eLane[d]));
      checkOutput($sformatf("aligned[%0d]", d), 32'(oAligned), 32'(mAligned[d]));
      checkOutput($sformatf("load_idle_ack[%0d]", d), 32'(oPulse), 32'(ePulse[d]));
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 4; k++) begin
        srcPend[d][k] = 1'b0;
        srcByte[d][k] = 8'h00;
      end

    repeat (3) runCycle(1'b0);

    $display("[TB] preamble then idle fill");
    mode = 0;
    repeat (48) runCycle(1'b1);

    $display("[TB] all lanes valid, rotation");
    mode = 1;
    repeat (64) runCycle(1'b1);

    $display("[TB] lanes 0 and 3 only");
    mode = 2;
    repeat (64) runCycle(1'b1);

    $display("[TB] link_en drop for one slot");
    mode = 1;
    linkTarget = 1'b0;
    repeat (8) runCycle(1'b1);
    linkTarget = 1'b1;
    repeat (48) runCycle(1'b1);

    $display("[TB] reset mid-slot");
    while (cnt % 8 != 4) runCycle(1'b1);
    runCycle(1'b0);
    repeat (64) runCycle(1'b1);

    $display("[TB] randomized traffic");
    mode = 3;
    for (int n = 0; n < 1600; n++) begin
      if (cnt % 8 == 0) linkTarget = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 299) == 0) runCycle(1'b0);
      else runCycle(1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_lane_scheduler.md
Name: tx_lane_scheduler

Overview:
Transmit-side byte scheduler feeding the parallel-to-serial stage of the 4-lane link, all on clk_32f.
- Generates the 8-cycle byte-slot timing.
- After reset, or when the link is disabled, emits a COM (8'hBC) alignment preamble.
- Once aligned, shares the single serializer slot among lanes 0..3 with round-robin arbitration.
- Inserts an IDLE symbol whenever no lane has data.

Parameters:
SYNC_COUNT, 4, number of consecutive COM symbols sent before entering ACTIVE (legal range 1..15)
COM_SYM, 8'hBC, alignment symbol
IDLE_SYM, 8'hBC, filler symbol sent in ACTIVE when no lane is valid

Ports:
clk_32f  input  1  bit clock; only clock of the block
reset_L  input  1  synchronous, active-low reset
link_en  input  1  1 = allow ACTIVE; 0 = force realignment
in0..in3  input  8 each  lane data bytes
valid_in0..valid_in3  input  1 each  lane k holds a byte
ack_out0..ack_out3  output  1 each  one-cycle pulse: lane k byte consumed; source advances
byte_out  output  8  byte handed to serializer
byte_load  output  1  one-cycle pulse: byte_out is new; serializer loads it
lane_sel  output  2  lane that sourced byte_out (0 for COM/IDLE)
aligned  output  1  high while in ACTIVE
idle_ins  output  1  one-cycle pulse when IDLE_SYM is loaded

Behaviour:
Clock and reset:
- Single clock clk_32f.
- Reset is synchronous, active-low, on reset_L, sampled on the clk_32f rising edge.

Reset values (reset_L=0):
- Outputs: byte_out=0, byte_load=0, ack_out*=0, lane_sel=0, aligned=0, idle_ins=0.
- Internal: state=ALIGN, bit_cnt=0, sync_cnt=0, rr_ptr=0.

Slot timing:
- bit_cnt is 3 bits and free-runs 0..7 and wraps, starting at the first edge with reset_L=1.
- The decision edge is the edge at which bit_cnt==7.
- All registered outputs update only at decision edges. byte_load, ack_out*, and idle_ins pulse for exactly the cycle following a decision edge.
- First byte_load occurs 8 cycles after reset release; thereafter one every 8 cycles.

FSM states, evaluated at decision edges:
- ALIGN:
  - byte_out=COM_SYM, lane_sel=0, no ack, sync_cnt+=1.
  - When sync_cnt reaches SYNC_COUNT: go to ACTIVE, sync_cnt=0.
  - link_en is ignored during ALIGN.
- ACTIVE, link_en=1:
  - Search lanes rr_ptr, rr_ptr+1, … (mod 4) for the first valid_in.
  - If found lane k: byte_out=in_k, lane_sel=k, ack_out_k=1, rr_ptr=(k+1) mod 4.
  - If none found: byte_out=IDLE_SYM, lane_sel=0, idle_ins=1, rr_ptr unchanged.
- ACTIVE, link_en=0 at a decision edge:
  - Load COM_SYM, no ack, go to ALIGN with sync_cnt=1. This COM counts toward the preamble.
- aligned = (state==ACTIVE), registered.

Source rules:
- in_k and valid_in_k are sampled only at decision edges.
- Source must hold the byte stable until ack_out_k.
- valid_in dropping between decision edges has no effect.

Boundary conditions:
- All four lanes valid continuously: strict rotation 0,1,2,3,0…
- Single lane valid continuously: that lane gets every slot.
- Reset mid-slot: all state cleared the same edge; any in-flight ack is not issued.
- link_en toggling within a slot: only the value at the decision edge matters.

Decomposition:
- Shared package tx_link_pkg:
  - COM/IDLE symbol constants.
  - State encoding (ALIGN=1'b0, ACTIVE=1'b1).
  - NUM_LANES=4 and BYTE_BITS=8.
- Sub-module rr_arbiter4 (combinational):
  - Inputs: valid[3:0], rr_ptr[1:0].
  - Outputs: grant_valid, grant_idx[1:0].
  - Reused later by the Rx side.

Test Plan:
1. Reset release, link_en=1, no valid → byte_load at cycles 8,16,24,32 with byte_out=BC. aligned rises with the 4th load. Subsequent loads are BC with idle_ins=1.
2. Aligned; all valid; in0..3 = 8'hBD,8'hBA,8'hAB,8'h11 → consecutive loads BD,BA,AB,11 with lane_sel 0,1,2,3. Each ack_outk pulses once, coincident with its byte_load.
3. Aligned, rr_ptr=2; only valid_in0 and valid_in3 high → lane 3 served first, then lane 0. No lane starves.
4. Aligned; drop link_en before a decision edge → that load is BC with aligned=0. Exactly 3 more BC loads follow, then ACTIVE resumes.
5. reset_L=0 at bit_cnt=4 with valid lanes → next edge: all outputs 0, no ack. After release, the full 4-BC preamble repeats.
6. SYNC_COUNT=1 and IDLE_SYM=8'h7C override → one BC, then aligned. Idle slots show 7C with idle_ins=1.
